// File: rtl/if_id_fetch_queue.sv
// rtl/if_id_fetch_queue.sv - two-entry fetch-to-decode queue with head and look-ahead outputs
// Optional FETCH_STATS_EN adds saturating BubbleCount/FlushCount outputs.
module if_id_fetch_queue #(
  parameter int unsigned          WIDTH    = 32,
  parameter logic [WIDTH-1:0]     NOP_WORD = '0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] PCIn,
  input  logic [WIDTH-1:0] InstrIn,
  input  logic             InValid,
  output logic             InReady,
  input  logic             Stall,
  input  logic             Flush,
  output logic [WIDTH-1:0] InstrOut,
  output logic [WIDTH-1:0] PCPlus1Out,
  output logic             ValidOut,
  output logic [WIDTH-1:0] LookAhead,
  output logic             LookValid
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]      BubbleCount,
  output logic [15:0]      FlushCount
`endif
);

  logic             v0_q, v0_d, v1_q, v1_d;
  logic [WIDTH-1:0] pc0_q, pc0_d, pc1_q, pc1_d;
  logic [WIDTH-1:0] ins0_q, ins0_d, ins1_q, ins1_d;
  logic             push, pop;

  // Only a full queue held by decode refuses a word; a pop frees a slot otherwise.
  assign InReady = !(v0_q && v1_q && Stall);
  assign pop     = !Stall && v0_q;
  assign push    = InValid && InReady && !Flush;

  always_comb begin
    v0_d   = v0_q;
    v1_d   = v1_q;
    pc0_d  = pc0_q;
    pc1_d  = pc1_q;
    ins0_d = ins0_q;
    ins1_d = ins1_q;
    if (Flush) begin
      v0_d = 1'b0;
      v1_d = 1'b0;
    end else if (pop && !push) begin
      v0_d   = v1_q;
      pc0_d  = pc1_q;
      ins0_d = ins1_q;
      v1_d   = 1'b0;
    end else if (push && !pop) begin
      if (!v0_q) begin
        v0_d   = 1'b1;
        pc0_d  = PCIn;
        ins0_d = InstrIn;
      end else begin
        v1_d   = 1'b1;
        pc1_d  = PCIn;
        ins1_d = InstrIn;
      end
    end else if (push && pop) begin
      if (v1_q) begin
        pc0_d  = pc1_q;
        ins0_d = ins1_q;
        pc1_d  = PCIn;
        ins1_d = InstrIn;
      end else begin
        pc0_d  = PCIn;
        ins0_d = InstrIn;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      v0_q   <= 1'b0;
      v1_q   <= 1'b0;
      pc0_q  <= '0;
      pc1_q  <= '0;
      ins0_q <= '0;
      ins1_q <= '0;
    end else begin
      v0_q   <= v0_d;
      v1_q   <= v1_d;
      pc0_q  <= pc0_d;
      pc1_q  <= pc1_d;
      ins0_q <= ins0_d;
      ins1_q <= ins1_d;
    end
  end

  assign ValidOut   = v0_q;
  assign LookValid  = v1_q;
  assign InstrOut   = v0_q ? ins0_q : NOP_WORD;
  assign LookAhead  = v1_q ? ins1_q : NOP_WORD;
  assign PCPlus1Out = pc0_q + {{(WIDTH-1){1'b0}}, 1'b1};

`ifdef FETCH_STATS_EN
  logic [15:0] bubble_q, bubble_d, flush_q, flush_d;

  always_comb begin
    bubble_d = bubble_q;
    flush_d  = flush_q;
    if (!v0_q && bubble_q != 16'hFFFF) bubble_d = bubble_q + 16'd1;
    if (Flush && flush_q != 16'hFFFF)  flush_d  = flush_q + 16'd1;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      bubble_q <= '0;
      flush_q  <= '0;
    end else begin
      bubble_q <= bubble_d;
      flush_q  <= flush_d;
    end
  end

  assign BubbleCount = bubble_q;
  assign FlushCount  = flush_q;
`endif

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// tb/tb_if_id_fetch_queue.sv - scoreboard bench for if_id_fetch_queue (optional FETCH_STATS_EN)
module tb_if_id_fetch_queue;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] PCIn = '0, InstrIn = '0;
  logic        InValid = 1'b0, Stall = 1'b0, Flush = 1'b0;
  logic        InReady, ValidOut, LookValid;
  logic [31:0] InstrOut, PCPlus1Out, LookAhead;
`ifdef FETCH_STATS_EN
  logic [15:0] BubbleCount, FlushCount;
`endif

  if_id_fetch_queue #(.WIDTH(32), .NOP_WORD(32'h0000_0000)) dut (
    .Clk(Clk), .Reset(Reset), .PCIn(PCIn), .InstrIn(InstrIn), .InValid(InValid),
    .InReady(InReady), .Stall(Stall), .Flush(Flush), .InstrOut(InstrOut),
    .PCPlus1Out(PCPlus1Out), .ValidOut(ValidOut), .LookAhead(LookAhead), .LookValid(LookValid)
`ifdef FETCH_STATS_EN
    , .BubbleCount(BubbleCount), .FlushCount(FlushCount)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int          id;
    logic        v;
    logic [31:0] ins;
    logic        chk_p;
    logic [31:0] p1;
    logic        lv;
    logic [31:0] la;
    logic        rdy;
    logic        chk_s;
    logic [15:0] bc;
    logic [15:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   step_id = 0;
  bit   stim_done = 1'b0;

  task automatic step(input logic rst, input logic inv, input logic [31:0] pc, input logic [31:0] ins,
                      input logic stl, input logic fl,
                      input logic ev, input logic [31:0] ei, input logic chkp, input logic [31:0] ep,
                      input logic elv, input logic [31:0] ela, input logic erdy,
                      input logic chks, input logic [15:0] ebc, input logic [15:0] efc);
    exp_t e;
    @(posedge Clk);
    #1;
    Reset = rst; InValid = inv; PCIn = pc; InstrIn = ins; Stall = stl; Flush = fl;
    e.id = step_id; e.v = ev; e.ins = ei; e.chk_p = chkp; e.p1 = ep;
    e.lv = elv; e.la = ela; e.rdy = erdy; e.chk_s = chks; e.bc = ebc; e.fc = efc;
    exp_q.push_back(e);
    step_id++;
  endtask

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, id, act, req);
    end
  endtask

  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("ValidOut",  e.id, {31'b0, ValidOut},  {31'b0, e.v});
      chk("InstrOut",  e.id, InstrOut,           e.ins);
      chk("LookValid", e.id, {31'b0, LookValid}, {31'b0, e.lv});
      chk("LookAhead", e.id, LookAhead,          e.la);
      chk("InReady",   e.id, {31'b0, InReady},   {31'b0, e.rdy});
      if (e.chk_p) chk("PCPlus1Out", e.id, PCPlus1Out, e.p1);
`ifdef FETCH_STATS_EN
      if (e.chk_s) begin
        chk("BubbleCount", e.id, {16'b0, BubbleCount}, {16'b0, e.bc});
        chk("FlushCount",  e.id, {16'b0, FlushCount},  {16'b0, e.fc});
      end
`endif
    end
  end

  initial begin
    // rst inv pc instr stall flush | v instr chkp pc+1 | lv la rdy | chks bc fc
    step(0,0,32'h0,32'h0,0,0,                 0,32'h0,1,32'h1,          0,32'h0,1,         1,16'd0,16'd0);
    step(1,1,32'h0,32'h8C010004,0,0,          0,32'h0,0,32'h0,          0,32'h0,1,         0,16'd0,16'd0);
    step(1,1,32'h1,32'hA0000001,0,0,          1,32'h8C010004,1,32'h1,   0,32'h0,1,         0,16'd0,16'd0);
    step(1,1,32'h2,32'hA0000002,0,0,          1,32'hA0000001,1,32'h2,   0,32'h0,1,         0,16'd0,16'd0);
    step(1,0,32'h0,32'h0,0,0,                 1,32'hA0000002,1,32'h3,   0,32'h0,1,         0,16'd0,16'd0);
    step(1,0,32'h0,32'h0,1,0,                 0,32'h0,0,32'h0,          0,32'h0,1,         0,16'd0,16'd0);
    step(1,1,32'h4,32'hB0000004,1,0,          0,32'h0,0,32'h0,          0,32'h0,1,         0,16'd0,16'd0);
    step(1,1,32'h5,32'hB0000005,1,0,          1,32'hB0000004,1,32'h5,   0,32'h0,1,         0,16'd0,16'd0);
    step(1,1,32'h6,32'hB0000006,1,0,          1,32'hB0000004,1,32'h5,   1,32'hB0000005,0,  0,16'd0,16'd0);
    step(1,1,32'h6,32'hB0000006,1,0,          1,32'hB0000004,1,32'h5,   1,32'hB0000005,0,  0,16'd0,16'd0);
    step(1,1,32'h6,32'hB0000006,0,0,          1,32'hB0000004,1,32'h5,   1,32'hB0000005,1,  0,16'd0,16'd0);
    step(1,0,32'h0,32'h0,0,0,                 1,32'hB0000005,1,32'h6,   1,32'hB0000006,1,  0,16'd0,16'd0);
    step(1,1,32'h7,32'hC0000007,1,0,          1,32'hB0000006,1,32'h7,   0,32'h0,1,         0,16'd0,16'd0);
    step(1,1,32'h8,32'hC0000008,0,1,          1,32'hB0000006,1,32'h7,   1,32'hC0000007,1,  0,16'd0,16'd0);
    step(1,0,32'h0,32'h0,0,0,                 0,32'h0,0,32'h0,          0,32'h0,1,         0,16'd0,16'd0);
    step(1,1,32'hFFFFFFFF,32'hD0000000,0,0,   0,32'h0,0,32'h0,          0,32'h0,1,         0,16'd0,16'd0);
    step(1,1,32'h10,32'hD0000001,1,0,         1,32'hD0000000,1,32'h0,   0,32'h0,1,         0,16'd0,16'd0);
    // asynchronous reset with both entries queued
    step(0,0,32'h0,32'h0,1,0,                 0,32'h0,1,32'h1,          0,32'h0,1,         1,16'd0,16'd0);
    step(1,1,32'h0,32'h8C010004,0,0,          0,32'h0,0,32'h0,          0,32'h0,1,         1,16'd0,16'd0);
    step(1,0,32'h0,32'h0,0,0,                 1,32'h8C010004,1,32'h1,   0,32'h0,1,         1,16'd1,16'd0);
    step(1,0,32'h0,32'h0,0,0,                 0,32'h0,0,32'h0,          0,32'h0,1,         1,16'd1,16'd0);
    // three empty cycles then a flush
    step(0,0,32'h0,32'h0,0,0,                 0,32'h0,1,32'h1,          0,32'h0,1,         1,16'd0,16'd0);
    step(1,0,32'h0,32'h0,0,0,                 0,32'h0,0,32'h0,          0,32'h0,1,         1,16'd0,16'd0);
    step(1,0,32'h0,32'h0,0,0,                 0,32'h0,0,32'h0,          0,32'h0,1,         1,16'd1,16'd0);
    step(1,0,32'h0,32'h0,0,0,                 0,32'h0,0,32'h0,          0,32'h0,1,         1,16'd2,16'd0);
    step(1,0,32'h0,32'h0,0,1,                 0,32'h0,0,32'h0,          0,32'h0,1,         1,16'd3,16'd0);
    step(1,0,32'h0,32'h0,0,0,                 0,32'h0,0,32'h0,          0,32'h0,1,         1,16'd4,16'd1);
    stim_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    wait (stim_done);
    while (exp_q.size() > 0 && budget < 10) begin
      @(posedge Clk);
      budget++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end

endmodule
